// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : ooo_types (package)                                             |
// | Brief    : Shared types and constants for the data-memory responder.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package ooo_types;

    typedef enum logic [0:0] {
        DMEM_CLEAR = 1'b0,
        DMEM_READY = 1'b1
    } dmem_state_t;

    localparam int DMEM_DEPTH    = 256;
    localparam int DMEM_IDX_BITS = $clog2(DMEM_DEPTH);

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder_if                                               |
// | Brief    : LSU memory port plus debug/preload port of the data memory.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface dmem_responder_if #(
    parameter int IDX = 8
);
    logic [31:0]    mem_addr;
    logic           mem_en;
    logic           mem_we;
    logic [31:0]    mem_wdata;
    logic [31:0]    mem_rdata;
    logic           mem_ready;

    logic           dbg_valid;
    logic           dbg_we;
    logic [IDX-1:0] dbg_addr;
    logic [31:0]    dbg_wdata;
    logic           dbg_ready;
    logic           dbg_rvalid;
    logic [31:0]    dbg_rdata;

    logic           misalign_err;

    modport master (
        output mem_addr, mem_en, mem_we, mem_wdata,
        input  mem_rdata, mem_ready,
        output dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ready, dbg_rvalid, dbg_rdata,
        input  misalign_err
    );

    modport slave (
        input  mem_addr, mem_en, mem_we, mem_wdata,
        output mem_rdata, mem_ready,
        input  dbg_valid, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ready, dbg_rvalid, dbg_rdata,
        output misalign_err
    );

endinterface
`default_nettype wire

// File: rtl/dmem_responder_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_array                                                      |
// | Brief    : Single-port read-first word RAM with registered read data.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int IDX   = 8
) (
    input  wire logic            clk,
    input  wire logic            i_en,
    input  wire logic            i_we,
    input  wire logic [IDX-1:0]  i_idx,
    input  wire logic [31:0]     i_wdata,
    output logic      [31:0]     o_rdata
);

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;

    // No reset on the storage or read register so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end
            r_rdata <= r_mem[i_idx];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_responder                                                  |
// | Brief    : LSU data-memory responder with zero-clear and debug port.       |
// |            DMEM_MISALIGN_EN enables the sticky misaligned-access flag.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_responder
    import ooo_types::*;
#(
    parameter int DEPTH          = DMEM_DEPTH,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  wire logic       clk,
    input  wire logic       rst,
    dmem_responder_if.slave bus
);

    localparam int               c_IDX      = $clog2(DEPTH);
    localparam logic [c_IDX-1:0] c_LAST_IDX = c_IDX'(DEPTH - 1);

    dmem_state_t      r_state;
    dmem_state_t      w_state_nxt;
    logic [c_IDX-1:0] r_clr_idx;
    logic [c_IDX-1:0] w_clr_idx_nxt;

    logic             w_ready;
    logic [c_IDX-1:0] w_lsu_idx;
    logic             w_lsu_req;
    logic             w_dbg_ready;
    logic             w_dbg_req;

    logic             w_arr_en;
    logic             w_arr_we;
    logic [c_IDX-1:0] w_arr_idx;
    logic [31:0]      w_arr_wdata;
    logic [31:0]      w_arr_rdata;

    logic             r_lsu_rd;
    logic             r_dbg_rd;
    logic [31:0]      r_mem_hold;
    logic [31:0]      r_dbg_hold;
    logic [31:0]      w_mem_rdata;
    logic [31:0]      w_dbg_rdata;

    logic             w_unused_addr;

    assign w_ready     = (r_state == DMEM_READY);
    assign w_lsu_idx   = bus.mem_addr[c_IDX+1:2];
    assign w_lsu_req   = w_ready & bus.mem_en;
    assign w_dbg_ready = w_ready & ~bus.mem_en;
    assign w_dbg_req   = w_dbg_ready & bus.dbg_valid;

    assign w_unused_addr = ^{bus.mem_addr[31:c_IDX+2], bus.mem_addr[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= CLEAR_ON_RESET ? DMEM_CLEAR : DMEM_READY;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        case (r_state)
            DMEM_CLEAR: begin
                w_clr_idx_nxt = r_clr_idx + 1'b1;
                if (r_clr_idx == c_LAST_IDX) begin
                    w_state_nxt = DMEM_READY;
                end
            end
            DMEM_READY: begin
                w_state_nxt = DMEM_READY;
            end
            default: begin
                w_state_nxt = DMEM_CLEAR;
            end
        endcase
    end

    // Single RAM port: clear walk, then LSU, then debug in falling priority.
    always_comb begin
        w_arr_en    = 1'b0;
        w_arr_we    = 1'b0;
        w_arr_idx   = '0;
        w_arr_wdata = '0;
        if (rst) begin
            w_arr_en = 1'b0;
        end else if (!w_ready) begin
            w_arr_en  = 1'b1;
            w_arr_we  = 1'b1;
            w_arr_idx = r_clr_idx;
        end else if (w_lsu_req) begin
            w_arr_en    = 1'b1;
            w_arr_we    = bus.mem_we;
            w_arr_idx   = w_lsu_idx;
            w_arr_wdata = bus.mem_wdata;
        end else if (w_dbg_req) begin
            w_arr_en    = 1'b1;
            w_arr_we    = bus.dbg_we;
            w_arr_idx   = bus.dbg_addr;
            w_arr_wdata = bus.dbg_wdata;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX   (c_IDX)
    ) u_array (
        .clk     (clk),
        .i_en    (w_arr_en),
        .i_we    (w_arr_we),
        .i_idx   (w_arr_idx),
        .i_wdata (w_arr_wdata),
        .o_rdata (w_arr_rdata)
    );

    // The shared RAM read register is steered to whichever port issued last;
    // the hold registers keep each port's data stable between its own accesses.
    assign w_mem_rdata = r_lsu_rd ? w_arr_rdata : r_mem_hold;
    assign w_dbg_rdata = r_dbg_rd ? w_arr_rdata : r_dbg_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lsu_rd   <= 1'b0;
            r_dbg_rd   <= 1'b0;
            r_mem_hold <= '0;
            r_dbg_hold <= '0;
        end else begin
            r_lsu_rd   <= w_lsu_req;
            r_dbg_rd   <= w_dbg_req & ~bus.dbg_we;
            r_mem_hold <= w_mem_rdata;
            r_dbg_hold <= w_dbg_rdata;
        end
    end

    assign bus.mem_rdata  = w_mem_rdata;
    assign bus.mem_ready  = w_ready;
    assign bus.dbg_ready  = w_dbg_ready;
    assign bus.dbg_rvalid = r_dbg_rd;
    assign bus.dbg_rdata  = w_dbg_rdata;

`ifdef DMEM_MISALIGN_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_misalign <= 1'b0;
        end else if (w_lsu_req && (bus.mem_addr[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign bus.misalign_err = r_misalign;
`else
    assign bus.misalign_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_responder                                               |
// | Brief    : Directed self-checking bench for dmem_responder (DEPTH=256).    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

`ifdef DMEM_MISALIGN_EN
    localparam logic c_MIS = 1'b1;
`else
    localparam logic c_MIS = 1'b0;
`endif

    logic clk;
    logic rst;
    int   n_vec;
    int   n_err;
    int   cnt;

    dmem_responder_if #(.IDX(8)) bus ();

    dmem_responder #(
        .DEPTH          (256),
        .CLEAR_ON_RESET (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lsu(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        bus.mem_en    = 1'b1;
        bus.mem_we    = we;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        tick(1);
        bus.mem_en = 1'b0;
        bus.mem_we = 1'b0;
    endtask

    task automatic dbg_access(input logic we, input logic [7:0] idx, input logic [31:0] wdata);
        bus.dbg_valid = 1'b1;
        bus.dbg_we    = we;
        bus.dbg_addr  = idx;
        bus.dbg_wdata = wdata;
        tick(1);
        bus.dbg_valid = 1'b0;
        bus.dbg_we    = 1'b0;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        do begin
            tick(1);
            n++;
        end while (!bus.mem_ready && n < 400);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b1;
        bus.mem_en = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
        bus.dbg_valid = 1'b0; bus.dbg_we = 1'b0; bus.dbg_addr = '0; bus.dbg_wdata = '0;

        // Reset state and clear duration
        tick(3);
        check_value("rst_mem_rdata",  bus.mem_rdata, 32'd0);
        check_value("rst_dbg_rdata",  bus.dbg_rdata, 32'd0);
        check_value("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'd0);
        check_value("rst_misalign",   32'(bus.misalign_err), 32'd0);
        check_value("rst_mem_ready",  32'(bus.mem_ready), 32'd0);
        rst = 1'b0;
        bus.dbg_valid = 1'b1;
        #1;
        check_value("clear_dbg_ready", 32'(bus.dbg_ready), 32'd0);
        bus.dbg_valid = 1'b0;
        wait_ready(cnt);
        check_value("clear_cycles", cnt, 32'd256);

        dbg_access(1'b0, 8'd255, 32'd0);
        check_value("dbg255_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check_value("dbg255_rdata",  bus.dbg_rdata, 32'd0);
        tick(1);
        check_value("dbg_rvalid_pulse", 32'(bus.dbg_rvalid), 32'd0);

        // Preload word i = i*10
        for (int i = 0; i < 256; i++) begin
            dbg_access(1'b1, 8'(i), 32'(i * 10));
        end
        check_value("preload_no_rvalid", 32'(bus.dbg_rvalid), 32'd0);

        lsu(32'h108, 1'b0, 32'd0);
        check_value("load_108", bus.mem_rdata, 32'd660);
        tick(1);
        check_value("load_108_hold", bus.mem_rdata, 32'd660);

        // Read-first store, then load of the stored value
        lsu(32'h10, 1'b1, 32'hDEAD_BEEF);
        check_value("store_10_old", bus.mem_rdata, 32'd40);
        lsu(32'h10, 1'b0, 32'd0);
        check_value("load_10_new", bus.mem_rdata, 32'hDEAD_BEEF);
        check_value("aligned_no_misalign", 32'(bus.misalign_err), 32'd0);

        // LSU priority over a held debug read
        bus.dbg_valid = 1'b1; bus.dbg_we = 1'b0; bus.dbg_addr = 8'd5;
        bus.mem_en = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h8;
        #1;
        check_value("b2b_dbg_ready0", 32'(bus.dbg_ready), 32'd0);
        tick(1);
        check_value("b2b_load_8", bus.mem_rdata, 32'd20);
        check_value("b2b_rvalid0", 32'(bus.dbg_rvalid), 32'd0);
        bus.mem_addr = 32'hC;
        #1;
        check_value("b2b_dbg_ready1", 32'(bus.dbg_ready), 32'd0);
        tick(1);
        check_value("b2b_load_c", bus.mem_rdata, 32'd30);
        check_value("b2b_rvalid1", 32'(bus.dbg_rvalid), 32'd0);
        bus.mem_en = 1'b0;
        #1;
        check_value("idle_dbg_ready", 32'(bus.dbg_ready), 32'd1);
        tick(1);
        bus.dbg_valid = 1'b0;
        check_value("dbg5_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check_value("dbg5_rdata",  bus.dbg_rdata, 32'd50);
        check_value("dbg_keeps_mem_rdata", bus.mem_rdata, 32'd30);
        tick(1);
        check_value("dbg_rdata_hold", bus.dbg_rdata, 32'd50);

        // Wrapped, misaligned load
        lsu(32'h0000_0406, 1'b0, 32'd0);
        check_value("load_406", bus.mem_rdata, 32'd10);
        check_value("misalign_set", 32'(bus.misalign_err), 32'(c_MIS));
        lsu(32'h0, 1'b0, 32'd0);
        check_value("load_0", bus.mem_rdata, 32'd0);
        tick(3);
        check_value("misalign_sticky", 32'(bus.misalign_err), 32'(c_MIS));
        lsu(32'h4, 1'b0, 32'd0);
        check_value("load_4", bus.mem_rdata, 32'd10);

        // Reset mid-clear restarts; LSU ignored during clear
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_value("rst2_misalign", 32'(bus.misalign_err), 32'd0);
        check_value("rst2_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick(49);
        lsu(32'h20, 1'b1, 32'h0000_1234);
        check_value("clear_lsu_rdata", bus.mem_rdata, 32'd0);
        check_value("clear_mem_ready", 32'(bus.mem_ready), 32'd0);
        tick(50);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_ready(cnt);
        check_value("reclear_cycles", cnt, 32'd256);
        lsu(32'h20, 1'b0, 32'd0);
        check_value("clear_ignored_store", bus.mem_rdata, 32'd0);
        lsu(32'h3FC, 1'b0, 32'd0);
        check_value("reclear_word255", bus.mem_rdata, 32'd0);
        dbg_access(1'b0, 8'd100, 32'd0);
        check_value("reclear_dbg100_rvalid", 32'(bus.dbg_rvalid), 32'd1);
        check_value("reclear_dbg100_rdata",  bus.dbg_rdata, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
